// File: rtl/divider8_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a
// single WIDTH+1-bit subtractor, with start/done handshake and registered results.
module divider8_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  // Restored partial remainder is always below D, so its top bit is never
  // needed in storage; the full WIDTH+1 bits exist only in the trial result.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    r_shift = {r_reg, q_reg[WIDTH-1]};
    trial   = r_shift - {1'b0, d_reg};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_shift[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
          if (start) begin
            d_reg <= divisor;
            q_reg <= dividend;
            r_reg <= '0;
            if (divisor == '0) begin
              state_reg   <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_reg   <= RUN;
              busy        <= 1'b1;
              cnt_reg     <= CW'(WIDTH);
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg - CW'(1);
          // Last step publishes the post-step values directly.
          if (cnt_reg == CW'(1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider8_seq.sv
// Self-checking bench for divider8_seq: directed boundary cases plus random
// operands checked against plain integer division.
module tb_divider8_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int failures = 0;
  logic [7:0] prev_q = 8'd0;
  logic [7:0] prev_r = 8'd0;

  divider8_seq #(.WIDTH(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation; optional start pulse (other operands) or reset at a given
  // sample index, counted from the first cycle after start is taken.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input int inject_at, input int reset_at, input string tag);
    int lat;
    int busy_cnt;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    exp_q = (b == 0) ? 8'd255 : 8'(int'(a) / int'(b));
    exp_r = (b == 0) ? a : 8'(int'(a) % int'(b));
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat <= 20) begin
      if (busy === 1'b1) busy_cnt++;
      check({tag, "_hold_q"}, quotient, prev_q);
      check({tag, "_hold_r"}, remainder, prev_r);
      start = (lat == inject_at);
      if (lat == inject_at) begin
        dividend = 8'd9; divisor = 8'd2;
      end
      if (lat == reset_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done"}, done, 0);
        check({tag, "_rst_q"}, quotient, 0);
        check({tag, "_rst_r"}, remainder, 0);
        check({tag, "_rst_dbz"}, div_by_zero, 0);
        prev_q = 8'd0; prev_r = 8'd0;
        repeat (3) begin
          @(negedge clk);
          check({tag, "_rst_nodone"}, done, 0);
        end
        reset_n = 1'b1;
        repeat (10) begin
          @(negedge clk);
          check({tag, "_after_rst_done"}, done, 0);
          check({tag, "_after_rst_busy"}, busy, 0);
        end
        $display("op %s %0d/%0d aborted by reset", tag, a, b);
        return;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, (b == 0) ? 1 : 9);
    check({tag, "_busy_cycles"}, busy_cnt, (b == 0) ? 0 : 8);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_dbz"}, div_by_zero, (b == 0) ? 1 : 0);
    $display("op %s %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b,
             quotient, remainder, div_by_zero, lat);
    prev_q = exp_q;
    prev_r = exp_r;
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset held with start high: reset must win.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    do_div(8'd100, 8'd7, 0, 0, "basic");
    do_div(8'd255, 8'd1, 0, 0, "255by1");
    do_div(8'd5, 8'd9, 0, 0, "5by9");
    do_div(8'd255, 8'd255, 0, 0, "255by255");
    do_div(8'd0, 8'd3, 0, 0, "0by3");
    do_div(8'd42, 8'd0, 0, 0, "42by0");
    do_div(8'd10, 8'd3, 0, 0, "10by3");

    // start pulsed during the 3rd busy cycle must be ignored
    do_div(8'd200, 8'd13, 3, 0, "ignore");
    repeat (4) begin
      @(negedge clk);
      check("ignore_hold_q", quotient, 15);
      check("ignore_hold_r", remainder, 5);
      check("ignore_no_done", done, 0);
      check("ignore_idle_busy", busy, 0);
    end

    // Back-to-back with start held high through the done cycle
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 8'd8;
    @(negedge clk);
    divisor = 8'd9;
    lat = 1;
    while (done !== 1'b1 && lat <= 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b1_latency", lat, 9);
    check("b2b1_q", quotient, 9);
    check("b2b1_r", remainder, 5);
    $display("op b2b1 77/8 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
    lat = 0;
    @(negedge clk);
    lat = 1;
    check("b2b2_busy", busy, 1);
    while (done !== 1'b1 && lat <= 20) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("b2b_spacing", lat, 9);
    check("b2b2_q", quotient, 8);
    check("b2b2_r", remainder, 5);
    $display("op b2b2 77/9 -> q=%0d r=%0d spacing=%0d", quotient, remainder, lat);
    prev_q = 8'd8; prev_r = 8'd5;
    @(negedge clk);
    check("b2b_done_pulse", done, 0);

    // Reset during the 4th busy cycle, then rerun from power-up state
    do_div(8'd100, 8'd7, 0, 4, "rstmid");
    do_div(8'd100, 8'd7, 0, 0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      do_div(ra, rb, 0, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
